// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered grant index, valid flag and
// hold-limit timeout pulse. Grants are always separated by at least one idle cycle.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       release_i,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit               LIM_EN = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] LIM    = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       winner;
    logic             end_rel, end_wd, end_lim;

    // Scan offsets high to low so the nearest set bit at or after ptr wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        w = p;
        for (int i = 3; i >= 0; i--) begin
            if (r[p + 2'(i)]) w = p + 2'(i);
        end
        return w;
    endfunction

    always_comb begin
        winner  = pick(req, ptr);
        end_rel = release_i;
        end_wd  = !req[gnt_idx];
        end_lim = LIM_EN && (hold_cnt == LIM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 2'b00;
            hold_cnt  <= '0;
        end else if (state == IDLE) begin
            timeout <= 1'b0;
            if (|req) begin
                gnt_idx   <= winner;
                gnt_valid <= 1'b1;
                hold_cnt  <= '0;
                state     <= GRANT;
            end
        end else begin
            if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
            if (end_rel || end_wd || end_lim) begin
                gnt_valid <= 1'b0;
                state     <= IDLE;
                ptr       <= gnt_idx + 2'd1;
                // Only a pure hold-limit expiry counts as a timeout.
                timeout   <= end_lim && !end_rel && !end_wd;
            end else begin
                timeout <= 1'b0;
            end
        end
    end

endmodule
